// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle control FSM for the 4-bit-opcode datapath.
//               Sequences each instruction through fetch, decode, execute,
//               memory and write-back states, handshakes memory accesses
//               with mem_ready_i, selects register windows and counts
//               retired instructions.
// Ports       :
//   clk, rst        - clock, asynchronous active-high reset
//   opcode_i        - instruction register [15:12]
//   func_type_i     - R-type function field
//   zero_i          - ALU zero flag
//   mem_ready_i     - memory completed the current access this cycle
//   ir_ld_o/pc_ld_o - load instruction register / PC
//   pc_src_o        - 00 PC+1, 01 jump target, 10 branch target
//   adr_sel_o       - memory address: 0 PC, 1 ALU result
//   mem_rd_o/mem_wr_o                    - memory strobes
//   sel_imm_o/sel_alu_o/sel_mem_o/w_en_o - datapath selects, RF write
//   alu_func_o      - ALU operation
//   ldwnd_o/wnd_sel_o - window register load / window index
//   illegal_o       - one-cycle pulse on undecodable instruction
//   instr_count_o   - retired-instruction counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int FUNC_W      = 3,
  parameter int NUM_WINDOWS = 4,
  parameter int CNT_W       = 16,
  localparam int WND_W      = $clog2(NUM_WINDOWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode_i,
  input  logic [7:0]        func_type_i,
  input  logic              zero_i,
  input  logic              mem_ready_i,
  output logic              ir_ld_o,
  output logic              pc_ld_o,
  output logic [1:0]        pc_src_o,
  output logic              adr_sel_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic              sel_imm_o,
  output logic              sel_alu_o,
  output logic              sel_mem_o,
  output logic              w_en_o,
  output logic [FUNC_W-1:0] alu_func_o,
  output logic              ldwnd_o,
  output logic [WND_W-1:0]  wnd_sel_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  instr_count_o
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_WB     = 4'd4,
    S_MEMADR = 4'd5,
    S_LOAD   = 4'd6,
    S_LWB    = 4'd7,
    S_STORE  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [FUNC_W-1:0] ALU_ADD = FUNC_W'(1);

  state_t              state_q, state_d;
  logic [FUNC_W-1:0]   func_q, func_d;     // ALU function captured in DECODE
  logic                imm_q, imm_d;       // immediate operand captured in DECODE
  logic                store_q, store_d;   // memory op is a store
  logic [CNT_W-1:0]    cnt_q;
  logic                retire;

  // R-type one-hot function decode: exactly one of bits 0..5 set.
  logic                rtype_hit;
  logic [FUNC_W-1:0]   rtype_idx;
  logic                win_ok;

  always_comb begin
    rtype_hit = 1'b0;
    rtype_idx = '0;
    for (int k = 0; k < 6; k++) begin
      if (func_type_i == 8'(1 << k)) begin
        rtype_hit = 1'b1;
        rtype_idx = FUNC_W'(k);
      end
    end
  end

  assign win_ok = ({25'd0, func_type_i[6:0]} < 32'(NUM_WINDOWS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      func_q  <= '0;
      imm_q   <= 1'b0;
      store_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      imm_q   <= imm_d;
      store_q <= store_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    imm_d      = imm_q;
    store_d    = store_q;
    retire     = 1'b0;
    ir_ld_o    = 1'b0;
    pc_ld_o    = 1'b0;
    pc_src_o   = 2'b00;
    adr_sel_o  = 1'b0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    sel_imm_o  = 1'b0;
    sel_alu_o  = 1'b0;
    sel_mem_o  = 1'b0;
    w_en_o     = 1'b0;
    alu_func_o = '0;
    ldwnd_o    = 1'b0;
    wnd_sel_o  = '0;
    illegal_o  = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ir_ld_o = 1'b1;
          pc_ld_o = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Clear the captured operation so non-EXEC paths leave nothing stale.
        state_d = S_FETCH;
        func_d  = '0;
        imm_d   = 1'b0;
        case (opcode_i)
          4'b0000, 4'b0001: begin
            state_d = S_MEMADR;
            store_d = opcode_i[0];
          end
          4'b0010: begin
            pc_ld_o  = 1'b1;
            pc_src_o = 2'b01;
            retire   = 1'b1;
          end
          4'b0100: state_d = S_BRANCH;
          4'b1000: begin
            if (rtype_hit) begin
              state_d = S_EXEC;
              func_d  = rtype_idx;
            end else if (func_type_i == 8'h40) begin
              retire = 1'b1;
            end else if (func_type_i[7] && win_ok) begin
              ldwnd_o   = 1'b1;
              wnd_sel_o = func_type_i[WND_W-1:0];
              retire    = 1'b1;
            end else begin
              illegal_o = 1'b1;
            end
          end
          4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
            state_d = S_EXEC;
            imm_d   = 1'b1;
            func_d  = FUNC_W'({1'b0, opcode_i[1:0]} + 3'd1);
          end
          default: illegal_o = 1'b1;
        endcase
      end

      S_EXEC: begin
        alu_func_o = func_q;
        sel_imm_o  = imm_q;
        sel_alu_o  = |func_q;
        state_d    = S_WB;
      end

      S_WB: begin
        alu_func_o = func_q;
        sel_imm_o  = imm_q;
        sel_alu_o  = |func_q;
        w_en_o     = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMADR: begin
        sel_imm_o  = 1'b1;
        alu_func_o = ALU_ADD;
        state_d    = store_q ? S_STORE : S_LOAD;
      end

      S_LOAD: begin
        mem_rd_o   = 1'b1;
        adr_sel_o  = 1'b1;
        sel_imm_o  = 1'b1;
        alu_func_o = ALU_ADD;
        if (mem_ready_i) state_d = S_LWB;
      end

      S_LWB: begin
        sel_mem_o = 1'b1;
        w_en_o    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_STORE: begin
        mem_wr_o  = 1'b1;
        adr_sel_o = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_BRANCH: begin
        alu_func_o = ALU_ADD;
        if (!zero_i) begin
          pc_ld_o  = 1'b1;
          pc_src_o = 2'b10;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      default: state_d = S_INIT;
    endcase
  end

  assign instr_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller. Each instruction
//               task pushes per-cycle expected outputs and counter values;
//               the drain loop applies the inputs and compares each cycle.
//               A second instance with a 2-bit counter checks wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_ld;
    logic [1:0] pc_src;
    logic       adr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       sel_imm;
    logic       sel_alu;
    logic       sel_mem;
    logic       w_en;
    logic [2:0] alu_func;
    logic       ldwnd;
    logic [1:0] wnd_sel;
    logic       illegal;
  } ov_t;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  ft;
    logic        mr;
    logic        z;
    ov_t         exp;
    logic [15:0] cnt;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] opcode = '0;
  logic [7:0] func_type = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic ir_ld, pc_ld, adr_sel, mem_rd, mem_wr, sel_imm, sel_alu, sel_mem, w_en, ldwnd, illegal;
  logic [1:0] pc_src, wnd_sel;
  logic [2:0] alu_func;
  logic [15:0] cnt;

  logic d2_ir_ld, d2_pc_ld, d2_adr_sel, d2_mem_rd, d2_mem_wr, d2_sel_imm, d2_sel_alu;
  logic d2_sel_mem, d2_w_en, d2_ldwnd, d2_illegal;
  logic [1:0] d2_pc_src, d2_wnd_sel, cnt2;
  logic [2:0] d2_alu_func;

  ov_t obs;
  assign obs = {ir_ld, pc_ld, pc_src, adr_sel, mem_rd, mem_wr, sel_imm, sel_alu,
                sel_mem, w_en, alu_func, ldwnd, wnd_sel, illegal};

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode_i(opcode), .func_type_i(func_type), .zero_i(zero),
    .mem_ready_i(mem_ready), .ir_ld_o(ir_ld), .pc_ld_o(pc_ld), .pc_src_o(pc_src),
    .adr_sel_o(adr_sel), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .sel_imm_o(sel_imm),
    .sel_alu_o(sel_alu), .sel_mem_o(sel_mem), .w_en_o(w_en), .alu_func_o(alu_func),
    .ldwnd_o(ldwnd), .wnd_sel_o(wnd_sel), .illegal_o(illegal), .instr_count_o(cnt)
  );

  multicycle_controller #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .opcode_i(opcode), .func_type_i(func_type), .zero_i(zero),
    .mem_ready_i(mem_ready), .ir_ld_o(d2_ir_ld), .pc_ld_o(d2_pc_ld), .pc_src_o(d2_pc_src),
    .adr_sel_o(d2_adr_sel), .mem_rd_o(d2_mem_rd), .mem_wr_o(d2_mem_wr), .sel_imm_o(d2_sel_imm),
    .sel_alu_o(d2_sel_alu), .sel_mem_o(d2_sel_mem), .w_en_o(d2_w_en), .alu_func_o(d2_alu_func),
    .ldwnd_o(d2_ldwnd), .wnd_sel_o(d2_wnd_sel), .illegal_o(d2_illegal), .instr_count_o(cnt2)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] cnt_m = '0;
  logic [3:0]  g_op;
  logic [7:0]  g_ft;
  ent_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // mr/z < 0 means "don't care": driven randomly to prove the input is ignored.
  task automatic push_e(input ov_t o, input int mr, input int z, input bit ret, input bit dec);
    ent_t e;
    e.op  = dec ? g_op : 4'($urandom);
    e.ft  = dec ? g_ft : 8'($urandom);
    e.mr  = (mr < 0) ? 1'($urandom) : mr[0];
    e.z   = (z < 0) ? 1'($urandom) : z[0];
    e.exp = o;
    e.cnt = cnt_m;
    if (ret) cnt_m = cnt_m + 16'd1;
    sb.push_back(e);
  endtask

  task automatic p_init();
    push_e('0, -1, -1, 0, 0);
  endtask

  task automatic p_fetch(input int wait_n);
    ov_t o;
    for (int i = 0; i < wait_n; i++) begin
      o = '0; o.mem_rd = 1'b1;
      push_e(o, 0, -1, 0, 0);
    end
    o = '0; o.mem_rd = 1'b1; o.ir_ld = 1'b1; o.pc_ld = 1'b1;
    push_e(o, 1, -1, 0, 0);
  endtask

  task automatic p_dec(input logic [3:0] op, input logic [7:0] ft, input ov_t o, input bit ret);
    g_op = op; g_ft = ft;
    push_e(o, -1, -1, ret, 1);
  endtask

  task automatic i_load(input int fw, input int lw);
    ov_t o;
    p_fetch(fw);
    p_dec(4'b0000, 8'($urandom), '0, 0);
    o = '0; o.sel_imm = 1'b1; o.alu_func = 3'd1;
    push_e(o, -1, -1, 0, 0);
    o.mem_rd = 1'b1; o.adr_sel = 1'b1;
    for (int i = 0; i < lw; i++) push_e(o, 0, -1, 0, 0);
    push_e(o, 1, -1, 0, 0);
    o = '0; o.sel_mem = 1'b1; o.w_en = 1'b1;
    push_e(o, -1, -1, 1, 0);
  endtask

  task automatic i_store(input int sw);
    ov_t o;
    p_fetch(0);
    p_dec(4'b0001, 8'($urandom), '0, 0);
    o = '0; o.sel_imm = 1'b1; o.alu_func = 3'd1;
    push_e(o, -1, -1, 0, 0);
    o = '0; o.mem_wr = 1'b1; o.adr_sel = 1'b1;
    for (int i = 0; i < sw; i++) push_e(o, 0, -1, 0, 0);
    push_e(o, 1, -1, 1, 0);
  endtask

  task automatic i_exec(input int fw, input logic [3:0] op, input logic [7:0] ft,
                        input logic [2:0] fn, input logic imm);
    ov_t o;
    p_fetch(fw);
    p_dec(op, ft, '0, 0);
    o = '0; o.alu_func = fn; o.sel_imm = imm; o.sel_alu = (fn != 3'd0);
    push_e(o, -1, -1, 0, 0);
    o.w_en = 1'b1;
    push_e(o, -1, -1, 1, 0);
  endtask

  task automatic i_jump();
    ov_t o;
    p_fetch(0);
    o = '0; o.pc_ld = 1'b1; o.pc_src = 2'b01;
    p_dec(4'b0010, 8'($urandom), o, 1);
  endtask

  task automatic i_branch(input logic z);
    ov_t o;
    p_fetch(0);
    p_dec(4'b0100, 8'($urandom), '0, 0);
    o = '0; o.alu_func = 3'd1;
    if (!z) begin o.pc_ld = 1'b1; o.pc_src = 2'b10; end
    push_e(o, -1, int'(z), 1, 0);
  endtask

  task automatic i_window(input logic [7:0] ft);
    ov_t o;
    p_fetch(0);
    o = '0; o.ldwnd = 1'b1; o.wnd_sel = ft[1:0];
    p_dec(4'b1000, ft, o, 1);
  endtask

  task automatic i_nop();
    p_fetch(0);
    p_dec(4'b1000, 8'h40, '0, 1);
  endtask

  task automatic i_illegal(input logic [3:0] op, input logic [7:0] ft);
    ov_t o;
    p_fetch(0);
    o = '0; o.illegal = 1'b1;
    p_dec(op, ft, o, 0);
  endtask

  task automatic drain();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      opcode = e.op; func_type = e.ft; mem_ready = e.mr; zero = e.z;
      #1;
      chk("outputs", 32'(obs), 32'(e.exp));
      chk("instr_count", 32'(cnt), 32'(e.cnt));
      chk("instr_count_w2", 32'(cnt2), 32'(e.cnt[1:0]));
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'(obs), 32'd0);
    chk("reset_count", 32'(cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    p_init();
    p_fetch(1);
    p_dec(4'b0000, 8'h00, '0, 0);
    push_e('{sel_imm: 1'b1, alu_func: 3'd1, default: '0}, -1, -1, 0, 0);
    push_e('{mem_rd: 1'b1, adr_sel: 1'b1, sel_imm: 1'b1, alu_func: 3'd1, default: '0}, 0, -1, 0, 0);
    drain();

    // Reset while LOAD waits on memory: strobe must drop immediately
    mem_ready = 1'b0;
    #1;
    chk("load_wait_mem_rd", 32'(mem_rd), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 32'(obs), 32'd0);
    chk("async_rst_count", 32'(cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_m = '0;
    p_init();
    // Five jumps: the 2-bit counter wraps 1,2,3,0,1
    for (int i = 0; i < 5; i++) i_jump();
    i_illegal(4'b0011, 8'h00);
    drain();

    i_exec(0, 4'b1000, 8'h04, 3'd2, 1'b0);   // R-type, alu_func 2
    i_exec(2, 4'b1000, 8'h01, 3'd0, 1'b0);   // alu_func 0 -> sel_alu 0, fetch stalls
    i_exec(0, 4'b1000, 8'h20, 3'd5, 1'b0);
    i_exec(0, 4'b1100, 8'h00, 3'd1, 1'b1);   // immediates
    i_exec(0, 4'b1111, 8'hFF, 3'd4, 1'b1);
    i_load(0, 0);
    i_load(0, 3);
    i_store(0);
    i_store(2);
    i_branch(1'b0);
    i_branch(1'b1);
    i_window(8'h83);
    i_window(8'h80);
    i_illegal(4'b1000, 8'h84);               // window out of range
    i_illegal(4'b1000, 8'h03);               // not one-hot
    i_illegal(4'b1000, 8'h00);
    i_illegal(4'b0111, 8'h01);
    i_nop();
    i_jump();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
